// File: rtl/bid_arb_pkg.sv
// Shared types and helpers for the sealed-bid slave arbiter.
package bid_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int DATA_W = 32;
  // Credit arithmetic is done wide enough that credit+refill never wraps.
  localparam int CALC_W = 16;

  function automatic logic [CALC_W-1:0] sat_add(
    input logic [CALC_W-1:0] base,
    input logic [CALC_W-1:0] amt,
    input logic [CALC_W-1:0] ceil
  );
    logic [CALC_W-1:0] sum;
    sum = base + amt;
    return (sum > ceil) ? ceil : sum;
  endfunction

endpackage

// File: rtl/bid_arbiter_select.sv
// Combinational highest-bid picker. With BID_TIE_RR_EN defined, ties rotate
// starting after rr_ptr; otherwise the lowest index wins a tie.
module bid_select #(
  parameter int NUM_M = 4,
  parameter int BID_W = 8
) (
  input  logic [NUM_M-1:0]       elig,
  input  logic [NUM_M*BID_W-1:0] bids,
`ifdef BID_TIE_RR_EN
  input  logic [$clog2(NUM_M)-1:0] rr_ptr,
`endif
  output logic [NUM_M-1:0]       win,
  output logic                   any_valid
);

  logic [BID_W-1:0] best_s;
  int               idx_s;

  assign any_valid = |elig;

  // Scan in priority order; strict '>' keeps the first-seen bidder on a tie.
  always_comb begin
    win    = '0;
    best_s = '0;
    idx_s  = 0;
    for (int k = 0; k < NUM_M; k++) begin
`ifdef BID_TIE_RR_EN
      idx_s = (int'(rr_ptr) + 1 + k) % NUM_M;
`else
      idx_s = k;
`endif
      if (elig[idx_s] && (bids[idx_s*BID_W +: BID_W] > best_s)) begin
        best_s     = bids[idx_s*BID_W +: BID_W];
        win        = '0;
        win[idx_s] = 1'b1;
      end else begin
        best_s = best_s;
      end
    end
  end

endmodule

// File: rtl/bid_arbiter.sv
// Sealed-bid arbiter sharing one slave across NUM_M credit-funded masters.
// Optional macro BID_TIE_RR_EN selects round-robin tie breaking.
module bid_arbiter
  import bid_arb_pkg::*;
#(
  parameter int NUM_M         = 4,
  parameter int BID_W         = 8,
  parameter int INIT_CREDIT   = 100,
  parameter int MAX_CREDIT    = 200,
  parameter int REFILL_AMT    = 10,
  parameter int REFILL_PERIOD = 64,
  parameter int ACC_CYCLES    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_M-1:0]        m_req,
  input  logic [NUM_M*BID_W-1:0]  m_bid,
  input  logic [NUM_M-1:0]        m_rw,
  input  logic [NUM_M*32-1:0]     m_addr,
  input  logic [NUM_M*32-1:0]     m_wdata,
  output logic [NUM_M-1:0]        m_gnt,
  output logic [NUM_M-1:0]        m_done,
  output logic [31:0]             m_rdata,
  output logic [NUM_M*BID_W-1:0]  credit,
  output logic                    sel,
  output logic                    RW,
  output logic [31:0]             addr,
  output logic [31:0]             DataToSlave,
  input  logic [31:0]             DataFromSlave
);

  localparam int IW  = $clog2(NUM_M);
  localparam int CW  = $clog2(ACC_CYCLES + 1);
  localparam int RCW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
  localparam logic [CW-1:0]    ACC_LOAD = CW'(ACC_CYCLES - 1);
  localparam logic [RCW-1:0]   RC_LAST  = RCW'(REFILL_PERIOD - 1);
  localparam logic [BID_W-1:0] INIT_C   = BID_W'(INIT_CREDIT);

  state_e             state_r, state_n;
  logic [CW-1:0]      count_r, count_n;
  logic [NUM_M-1:0]   elig_s, win_s, win_r, win_n, gnt_r, done_r;
  logic               any_s, start_s, cap_s, tick_s;
  logic [IW-1:0]      win_idx_s;
  logic               rw_r, sel_r;
  logic [DATA_W-1:0]  addr_r, wdata_r, rdata_r;
  logic [BID_W-1:0]   credit_r [NUM_M];
  logic [BID_W-1:0]   credit_n [NUM_M];
  logic [CALC_W-1:0]  sum_s;
  logic [RCW-1:0]     rcnt_r;
`ifdef BID_TIE_RR_EN
  logic [IW-1:0]      last_r;
`endif

  // A zero bid or one exceeding the balance is silently ignored.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_M; i++) begin
      elig_s[i] = m_req[i] && (m_bid[i*BID_W +: BID_W] != '0) &&
                  (m_bid[i*BID_W +: BID_W] <= credit_r[i]);
    end
  end

  bid_select #(.NUM_M(NUM_M), .BID_W(BID_W)) u_select (
    .elig      (elig_s),
    .bids      (m_bid),
`ifdef BID_TIE_RR_EN
    .rr_ptr    (last_r),
`endif
    .win       (win_s),
    .any_valid (any_s)
  );

  // One-hot winner to binary index.
  always_comb begin
    win_idx_s = '0;
    for (int i = 0; i < NUM_M; i++) begin
      win_idx_s = win_idx_s | (win_s[i] ? IW'(i) : IW'(0));
    end
  end

  assign tick_s = (rcnt_r == RC_LAST);

  // Next-state logic for the IDLE/ACCESS/DONE transaction sequence.
  always_comb begin
    state_n = state_r;
    count_n = count_r;
    start_s = 1'b0;
    cap_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_n = ACCESS;
          count_n = ACC_LOAD;
          start_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      ACCESS: begin
        if (count_r == '0) begin
          state_n = DONE;
          cap_s   = 1'b1;
        end else begin
          count_n = count_r - CW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    win_n = start_s ? win_s : win_r;
  end

  // Deduction and refill combine on one edge; width CALC_W prevents wrap.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < NUM_M; i++) begin
      sum_s = CALC_W'(credit_r[i]);
      if (start_s && win_s[i]) begin
        sum_s = sum_s - CALC_W'(m_bid[i*BID_W +: BID_W]);
      end else begin
        sum_s = sum_s;
      end
      if (tick_s) begin
        sum_s = sat_add(sum_s, CALC_W'(REFILL_AMT), CALC_W'(MAX_CREDIT));
      end else begin
        sum_s = sum_s;
      end
      credit_n[i] = BID_W'(sum_s);
    end
  end

  // Sequential state, registered outputs and credit balances.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= '0;
      win_r   <= '0;
      gnt_r   <= '0;
      done_r  <= '0;
      sel_r   <= 1'b0;
      rw_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      rcnt_r  <= '0;
      for (int i = 0; i < NUM_M; i++) credit_r[i] <= INIT_C;
`ifdef BID_TIE_RR_EN
      last_r  <= IW'(NUM_M - 1);
`endif
    end else begin
      state_r <= state_n;
      count_r <= count_n;
      win_r   <= win_n;
      sel_r   <= (state_n == ACCESS);
      gnt_r   <= (state_n == IDLE) ? '0 : win_n;
      done_r  <= (state_n == DONE) ? win_n : '0;
      if (start_s) begin
        rw_r    <= m_rw[win_idx_s];
        addr_r  <= m_addr[int'(win_idx_s)*DATA_W +: DATA_W];
        wdata_r <= m_wdata[int'(win_idx_s)*DATA_W +: DATA_W];
`ifdef BID_TIE_RR_EN
        last_r  <= win_idx_s;
`endif
      end
      if (cap_s && !rw_r) rdata_r <= DataFromSlave;
      rcnt_r <= tick_s ? '0 : rcnt_r + RCW'(1);
      for (int i = 0; i < NUM_M; i++) credit_r[i] <= credit_n[i];
    end
  end

  // Flatten balances for observation.
  always_comb begin
    credit = '0;
    for (int i = 0; i < NUM_M; i++) credit[i*BID_W +: BID_W] = credit_r[i];
  end

  assign m_gnt       = gnt_r;
  assign m_done      = done_r;
  assign m_rdata     = rdata_r;
  assign sel         = sel_r;
  assign RW          = rw_r;
  assign addr        = addr_r;
  assign DataToSlave = wdata_r;

endmodule

// File: tb/tb_bid_arbiter.sv
// Directed self-checking bench for bid_arbiter (default parameters).
module tb_bid_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   m_req;
  logic [31:0]  m_bid;
  logic [3:0]   m_rw;
  logic [127:0] m_addr;
  logic [127:0] m_wdata;
  logic [3:0]   m_gnt;
  logic [3:0]   m_done;
  logic [31:0]  m_rdata;
  logic [31:0]  credit;
  logic         sel;
  logic         RW;
  logic [31:0]  addr;
  logic [31:0]  DataToSlave;
  logic [31:0]  DataFromSlave;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  int who;
  int tie_exp [4];
  logic gnt3_seen;
  logic [7:0] c8;

  bid_arbiter dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_bid(m_bid), .m_rw(m_rw),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_done(m_done),
    .m_rdata(m_rdata), .credit(credit), .sel(sel), .RW(RW), .addr(addr),
    .DataToSlave(DataToSlave), .DataFromSlave(DataFromSlave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
    if (m_gnt[3]) gnt3_seen = 1'b1;
  endtask

  task automatic set_m(input int i, input logic req, input logic [7:0] bid,
                       input logic rw, input logic [31:0] a, input logic [31:0] wd);
    m_req[i]            = req;
    m_bid[i*8 +: 8]     = bid;
    m_rw[i]             = rw;
    m_addr[i*32 +: 32]  = a;
    m_wdata[i*32 +: 32] = wd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_req = '0; m_bid = '0; m_rw = '0; m_addr = '0; m_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    ecnt = 0;
  endtask

  // Returns the index of the master that gets m_done, or -1 after 20 cycles.
  task automatic wait_done(output int w);
    w = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_done != 4'b0000) begin
        for (int j = 0; j < 4; j++) if (m_done[j]) w = j;
        break;
      end
    end
  endtask

  initial begin
`ifdef BID_TIE_RR_EN
    tie_exp = '{0, 2, 0, 2};
`else
    tie_exp = '{0, 0, 0, 0};
`endif
    DataFromSlave = 32'hCAFE0001;
    gnt3_seen = 1'b0;

    // Reset state and single read
    do_reset();
    check_val("rst_sel", sel, 1'b0);
    check_val("rst_gnt", m_gnt, 4'b0000);
    check_val("rst_done", m_done, 4'b0000);
    check_val("rst_rdata", m_rdata, 32'h0);
    check_val("rst_credit", credit, 32'h64646464);
    set_m(1, 1'b1, 8'd5, 1'b0, 32'h10, 32'h0);
    tick();
    check_val("rd_sel1", sel, 1'b1);
    check_val("rd_gnt1", m_gnt, 4'b0010);
    check_val("rd_addr", addr, 32'h10);
    check_val("rd_rw", RW, 1'b0);
    check_val("rd_credit", credit, 32'h64645F64);
    tick();
    check_val("rd_sel2", sel, 1'b1);
    check_val("rd_done_early", m_done, 4'b0000);
    tick();
    check_val("rd_sel3", sel, 1'b0);
    check_val("rd_done", m_done, 4'b0010);
    check_val("rd_gnt3", m_gnt, 4'b0010);
    check_val("rd_rdata", m_rdata, 32'hCAFE0001);
    m_req[1] = 1'b0;
    tick();
    check_val("rd_done_clr", m_done, 4'b0000);
    check_val("rd_gnt_clr", m_gnt, 4'b0000);

    // Highest bid wins, then next highest; zero bid never granted
    do_reset();
    gnt3_seen = 1'b0;
    DataFromSlave = 32'hCAFE0001;
    set_m(0, 1'b1, 8'd3,  1'b0, 32'hA0, 32'h0);
    set_m(1, 1'b1, 8'd20, 1'b0, 32'hA1, 32'h0);
    set_m(2, 1'b1, 8'd7,  1'b1, 32'hA2, 32'h12345678);
    set_m(3, 1'b1, 8'd0,  1'b0, 32'hA3, 32'h0);
    wait_done(who);
    check_val("hb_first", who, 1);
    check_val("hb_rdata1", m_rdata, 32'hCAFE0001);
    m_req[1] = 1'b0;
    DataFromSlave = 32'hBEEF0002;
    wait_done(who);
    check_val("hb_second", who, 2);
    check_val("hb_wr_hold", m_rdata, 32'hCAFE0001);
    check_val("hb_wr_rw", RW, 1'b1);
    check_val("hb_wr_data", DataToSlave, 32'h12345678);
    check_val("hb_wr_addr", addr, 32'hA2);
    m_req[2] = 1'b0;
    wait_done(who);
    check_val("hb_third", who, 0);
    check_val("hb_rdata3", m_rdata, 32'hBEEF0002);
    m_req[0] = 1'b0;
    wait_done(who);
    check_val("hb_none", who, -1);
    check_val("hb_m3_never", gnt3_seen, 1'b0);
    check_val("hb_credit", credit, 32'h645D5061);
    m_req[3] = 1'b0;

    // Ineligible bid above balance is ignored
    do_reset();
    set_m(0, 1'b1, 8'd96, 1'b0, 32'h0, 32'h0);
    wait_done(who);
    check_val("ie_drain", who, 0);
    m_req[0] = 1'b0;
    check_val("ie_credit4", credit[7:0], 8'd4);
    set_m(0, 1'b1, 8'd9, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b1, 8'd5, 1'b0, 32'h0, 32'h0);
    wait_done(who);
    check_val("ie_other", who, 1);
    m_req[1] = 1'b0;
    wait_done(who);
    check_val("ie_never", who, -1);
    check_val("ie_credit", credit, 32'h64645F04);
    m_req = '0;

    // Tie between masters 0 and 2, requests held
    do_reset();
    set_m(0, 1'b1, 8'd10, 1'b0, 32'h0, 32'h0);
    set_m(2, 1'b1, 8'd10, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_done(who);
      check_val($sformatf("tie_%0d", k), who, tie_exp[k]);
    end
    m_req = '0;

    // Refill saturation and deduction on a refill edge
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      repeat (64) tick();
      c8 = (100 + 10 * k > 200) ? 8'd200 : 8'(100 + 10 * k);
      check_val($sformatf("refill_%0d", k), credit, {c8, c8, c8, c8});
    end
    set_m(1, 1'b1, 8'd5, 1'b0, 32'h0, 32'h0);
    wait_done(who);
    check_val("sat_win", who, 1);
    m_req[1] = 1'b0;
    check_val("sat_195", credit, 32'hC8C8C3C8);
    while (ecnt < 767) tick();
    set_m(1, 1'b1, 8'd50, 1'b0, 32'h0, 32'h0);
    tick();
    check_val("sat_combo", credit, 32'hC8C89BC8);
    wait_done(who);
    check_val("sat_combo_win", who, 1);
    m_req = '0;

    // Reset in the first ACCESS cycle
    do_reset();
    set_m(2, 1'b1, 8'd7, 1'b0, 32'h0, 32'h0);
    tick();
    check_val("mr_sel", sel, 1'b1);
    check_val("mr_credit_pre", credit, 32'h645D6464);
    rst = 1'b1;
    m_req = '0;
    tick();
    rst = 1'b0;
    check_val("mr_sel_drop", sel, 1'b0);
    check_val("mr_gnt", m_gnt, 4'b0000);
    check_val("mr_credit", credit, 32'h64646464);
    wait_done(who);
    check_val("mr_no_done", who, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bid_arbiter.md
Name: bid_arbiter

Overview:
- Shares one slave across NUM_M masters by sealed bidding.
- Each master holds a credit balance. The highest eligible bid wins one slave transaction, and the winning bid is deducted from that master's credit.
- Drives the slave side of the slave interface (slvR modport signal set) and returns read data to the winner.
- Credits refill periodically, so low bidders are not starved indefinitely.

Parameters:
NUM_M, 4, number of masters (2..8)
BID_W, 8, bid and credit width
INIT_CREDIT, 100, per-master credit after reset
MAX_CREDIT, 200, credit saturation ceiling
REFILL_AMT, 10, credit added per refill tick
REFILL_PERIOD, 64, cycles between refill ticks
ACC_CYCLES, 2, cycles s_sel is held per transaction (>=1)

Ports:
clk  in  1  positive-edge clock
rst  in  1  synchronous active-high reset
m_req  in  NUM_M  per-master request, held until m_done
m_bid  in  NUM_M*BID_W  per-master bid, held with req
m_rw  in  NUM_M  0=read, 1=write
m_addr  in  NUM_M*32  per-master address
m_wdata  in  NUM_M*32  per-master write data
m_gnt  out  NUM_M  one-hot grant, high from ACCESS through DONE
m_done  out  NUM_M  one-cycle completion pulse to winner
m_rdata  out  32  read data, valid while m_done high
credit  out  NUM_M*BID_W  current credit balances, for observation
sel  out  1  slave select
RW  out  1  slave read/write
addr  out  32  slave address
DataToSlave  out  32  slave write data
DataFromSlave  in  32  slave read data

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset: state=IDLE; m_gnt, m_done, sel, RW=0; addr, DataToSlave, m_rdata=0; all credits=INIT_CREDIT; refill counter=0.
- A master is eligible when m_req=1, m_bid!=0 and m_bid<=its credit. Ineligible requests are ignored, not errored.
- Winner selection:
  - Maximum bid among eligible masters wins.
  - Ties go to the lowest index (see Optional Feature).
- FSM:
  - IDLE: if any master is eligible at an edge, register winner w, its RW/addr/wdata, and deduct its bid; go to ACCESS with count=ACC_CYCLES-1. Otherwise stay.
  - ACCESS: sel=1, m_gnt[w]=1, slave buses driven from the registered copies. If count==0, capture DataFromSlave into m_rdata (reads only; hold the previous value on writes) and go to DONE. Otherwise decrement count.
  - DONE: m_done[w]=1 for exactly one cycle, m_gnt[w]=1, sel=0; go to IDLE.
- Timing: a request eligible at edge t gives sel high for cycles t+1..t+ACC_CYCLES and m_done at cycle t+ACC_CYCLES+1. Minimum grant-to-grant spacing is ACC_CYCLES+2 cycles.
- A master must deassert m_req in its DONE cycle or it re-enters arbitration at the next IDLE.
- Refill: the counter wraps at REFILL_PERIOD-1. On wrap, every credit becomes min(credit+REFILL_AMT, MAX_CREDIT).
- Simultaneous deduction and refill on one master: new credit = min(credit-bid+REFILL_AMT, MAX_CREDIT), computed at BID_W+1 bits so the addition cannot wrap. Credit never goes negative, because bid<=credit is enforced.
- Changes to bids or requests while not in IDLE have no effect on the current transaction.
- rst asserted mid-transaction: sel drops on the next edge, no m_done is issued, and credits return to INIT_CREDIT.

Optional Feature:
- Macro BID_TIE_RR_EN.
- Defined: ties are broken round-robin, starting the search at (last winner+1) mod NUM_M. The last-winner pointer resets to NUM_M-1, so index 0 wins the first tie.
- Undefined: ties always go to the lowest index; no pointer register exists.

Decomposition:
- Package bid_arb_pkg holds:
  - the state enum type (IDLE, ACCESS, DONE);
  - a localparam for the data/address width (32);
  - a function that saturating-adds a refill to a credit.
- Sub-module bid_select: purely combinational. Inputs are the eligible vector, bids and the optional rr pointer. Outputs are a one-hot winner and an any_valid flag.
- bid_arbiter contains the FSM, credit registers, refill counter and slave drive.

Test Plan:
- Single read: master1 bids 5 for address 0x10 while the slave returns 0xCAFE0001. Expect sel high for 2 cycles, m_done[1] at t+3, m_rdata=0xCAFE0001, credit[1]=95.
- Highest bid wins: bids {3,20,7,0} issued simultaneously. Expect master1 granted first; after its DONE, with requests still held, master2 wins next and then master0. Master3 is never granted.
- Ineligible bid: master0 at credit 4 bids 9. Expect it is never granted, and the other masters proceed normally.
- Tie: masters0 and 2 both bid 10, repeated four times. Expect grant order 0,0,0,0 without BID_TIE_RR_EN and 0,2,0,2 with it.
- Refill saturation: no requests for 64*11 cycles from reset. Expect credit to rise 110, 120, … and stay at 200. A win of bid 50 landing on a refill edge with credit 195 gives credit 155.
- Reset mid-ACCESS: assert rst during the first sel cycle. Expect sel=0 the next cycle, no m_done, and all credits back to 100.
